// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing generator: 640x480@60 defaults, totals,
// a ceiling-log2 helper and the colour-bit assignment of the test-pattern bars.
package vga_timing_pkg;

   localparam int unsigned CLK_DIV_DEF  = 4;
   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;

   localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   // Test pattern: eight bars, bar index bits select full-scale R/G/B.
   localparam int unsigned NUM_BARS      = 8;
   localparam int unsigned BAR_RED_BIT   = 0;
   localparam int unsigned BAR_GREEN_BIT = 1;
   localparam int unsigned BAR_BLUE_BIT  = 2;

   // Ceiling log2, never below 1 so a counter always has at least one bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 1;
      while ((64'd1 << r) < 64'(n)) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/px_en_div.sv
// Pixel-enable divider: counts system clocks while enabled and strobes o_px_en
// for one clock out of every CLK_DIV. Holds its count while i_enb is low.
module px_en_div
   import vga_timing_pkg::*;
#(
   parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
   input  logic clk,
   input  logic i_sclr,
   input  logic i_enb,
   output logic o_px_en
);

   localparam int unsigned   DW       = clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q, div_d;

   // Next divider value: advance and wrap only while enabled.
   always_comb begin
      div_d = div_q;
      if (i_enb) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
      end
   end

   // Divider state with asynchronous clear.
   always_ff @(posedge clk or posedge i_sclr) begin
      if (i_sclr) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   // Reset term keeps the strobe low during clear even when CLK_DIV is 1.
   assign o_px_en = i_enb & ~i_sclr & (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator and pixel output stage. Horizontal/vertical counters
// advance on each pixel strobe; markers are registered from the next counter
// values, and the colour/sync pins lag the counters by one pixel slot.
// Build option VGA_TIMING_PATTERN_EN replaces the external colour inputs with
// an internal eight-bar test pattern.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
   parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
   parameter int unsigned H_FP      = H_FP_DEF,
   parameter int unsigned H_SYNC    = H_SYNC_DEF,
   parameter int unsigned H_BP      = H_BP_DEF,
   parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
   parameter int unsigned V_FP      = V_FP_DEF,
   parameter int unsigned V_SYNC    = V_SYNC_DEF,
   parameter int unsigned V_BP      = V_BP_DEF,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b0,
   parameter int unsigned COLOR_W   = 4
) (
   input  logic                                                clk,
   input  logic                                                i_sclr,
   input  logic                                                i_enb,
   input  logic [COLOR_W-1:0]                                  i_red,
   input  logic [COLOR_W-1:0]                                  i_green,
   input  logic [COLOR_W-1:0]                                  i_blue,
   output logic                                                o_px_en,
   output logic [clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]         o_hidx,
   output logic [clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]         o_vidx,
   output logic                                                o_active,
   output logic                                                o_line_start,
   output logic                                                o_frame_start,
   output logic                                                o_vga_hsync,
   output logic                                                o_vga_vsync,
   output logic [COLOR_W-1:0]                                  o_vga_red,
   output logic [COLOR_W-1:0]                                  o_vga_green,
   output logic [COLOR_W-1:0]                                  o_vga_blue
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = clog2(H_TOTAL);
   localparam int unsigned VW      = clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

   // Sync windows compared in 32 bits so an end equal to the total cannot wrap.
   localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
   localparam int unsigned H_SYNC_END = H_ACTIVE + H_FP + H_SYNC;
   localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
   localparam int unsigned V_SYNC_END = V_ACTIVE + V_FP + V_SYNC;

   logic px_en;

   logic [HW-1:0]      hidx_q, hidx_d;
   logic [VW-1:0]      vidx_q, vidx_d;
   logic               active_q, active_d;
   logic               line_q, line_d;
   logic               frame_q, frame_d;
   logic               hs_q, hs_d;
   logic               vs_q, vs_d;
   logic [COLOR_W-1:0] red_q, red_d;
   logic [COLOR_W-1:0] green_q, green_d;
   logic [COLOR_W-1:0] blue_q, blue_d;
   logic [COLOR_W-1:0] src_red, src_green, src_blue;

   px_en_div #(
      .CLK_DIV (CLK_DIV)
   ) u_px_en_div (
      .clk     (clk),
      .i_sclr  (i_sclr),
      .i_enb   (i_enb),
      .o_px_en (px_en)
   );

`ifdef VGA_TIMING_PATTERN_EN
   // Bar width assumes H_ACTIVE >= NUM_BARS.
   localparam int unsigned BAR_W = H_ACTIVE / NUM_BARS;

   logic [2:0] bar;
   logic       unused_src;

   assign unused_src = ^{i_red, i_green, i_blue};

   // Pattern source: bar index from the current column, saturating at the last bar.
   always_comb begin
      if ((32'(hidx_q) / BAR_W) >= (NUM_BARS - 1)) begin
         bar = 3'd7;
      end else begin
         bar = 3'(32'(hidx_q) / BAR_W);
      end
      src_red   = {COLOR_W{bar[BAR_RED_BIT]}};
      src_green = {COLOR_W{bar[BAR_GREEN_BIT]}};
      src_blue  = {COLOR_W{bar[BAR_BLUE_BIT]}};
   end
`else
   // External source: image generator drives colour for the current index.
   always_comb begin
      src_red   = i_red;
      src_green = i_green;
      src_blue  = i_blue;
   end
`endif

   // Counter advance and marker decode from the post-advance position.
   always_comb begin
      hidx_d   = hidx_q;
      vidx_d   = vidx_q;
      active_d = active_q;
      line_d   = 1'b0;
      frame_d  = 1'b0;
      if (px_en) begin
         if (hidx_q == H_LAST) begin
            hidx_d = '0;
            vidx_d = (vidx_q == V_LAST) ? '0 : vidx_q + VW'(1);
         end else begin
            hidx_d = hidx_q + HW'(1);
         end
         active_d = (32'(hidx_d) < H_ACTIVE) && (32'(vidx_d) < V_ACTIVE);
         line_d   = (hidx_d == '0);
         frame_d  = (hidx_d == '0) && (vidx_d == '0);
      end
   end

   // Pin stage: decode from the current (pre-advance) position, one slot behind.
   always_comb begin
      hs_d    = hs_q;
      vs_d    = vs_q;
      red_d   = red_q;
      green_d = green_q;
      blue_d  = blue_q;
      if (px_en) begin
         hs_d    = ((32'(hidx_q) >= H_SYNC_BEG) && (32'(hidx_q) < H_SYNC_END)) ?
                   HSYNC_POL : ~HSYNC_POL;
         vs_d    = ((32'(vidx_q) >= V_SYNC_BEG) && (32'(vidx_q) < V_SYNC_END)) ?
                   VSYNC_POL : ~VSYNC_POL;
         red_d   = active_q ? src_red   : '0;
         green_d = active_q ? src_green : '0;
         blue_d  = active_q ? src_blue  : '0;
      end
   end

   // All timing and pin state; counters park at the last position so the first
   // strobe lands on (0,0).
   always_ff @(posedge clk or posedge i_sclr) begin
      if (i_sclr) begin
         hidx_q   <= H_LAST;
         vidx_q   <= V_LAST;
         active_q <= 1'b0;
         line_q   <= 1'b0;
         frame_q  <= 1'b0;
         hs_q     <= ~HSYNC_POL;
         vs_q     <= ~VSYNC_POL;
         red_q    <= '0;
         green_q  <= '0;
         blue_q   <= '0;
      end else begin
         hidx_q   <= hidx_d;
         vidx_q   <= vidx_d;
         active_q <= active_d;
         line_q   <= line_d;
         frame_q  <= frame_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         red_q    <= red_d;
         green_q  <= green_d;
         blue_q   <= blue_d;
      end
   end

   assign o_px_en       = px_en;
   assign o_hidx        = hidx_q;
   assign o_vidx        = vidx_q;
   assign o_active      = active_q;
   // Pulses are suppressed while frozen even if one was just registered.
   assign o_line_start  = line_q & i_enb;
   assign o_frame_start = frame_q & i_enb;
   assign o_vga_hsync   = hs_q;
   assign o_vga_vsync   = vs_q;
   assign o_vga_red     = red_q;
   assign o_vga_green   = green_q;
   assign o_vga_blue    = blue_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced geometry: a position model driven by the
// strobe count, directed literal checks, then randomized enable/colour/reset.
module tb_vga_timing_gen;

   localparam int D    = 3;
   localparam int HA   = 16;
   localparam int HFP  = 2;
   localparam int HS   = 3;
   localparam int HBP  = 2;
   localparam int VA   = 6;
   localparam int VFP  = 1;
   localparam int VS   = 2;
   localparam int VBP  = 1;
   localparam int HT   = HA + HFP + HS + HBP;
   localparam int VT   = VA + VFP + VS + VBP;
   localparam int HW   = $clog2(HT);
   localparam int VW   = $clog2(VT);
   localparam bit HPOL = 1'b0;
   localparam bit VPOL = 1'b1;

   logic          clk    = 1'b0;
   logic          i_sclr = 1'b1;
   logic          i_enb  = 1'b0;
   logic [3:0]    i_red  = 4'h0;
   logic [3:0]    i_green = 4'h0;
   logic [3:0]    i_blue = 4'h0;
   logic          o_px_en, o_active, o_line_start, o_frame_start;
   logic          o_vga_hsync, o_vga_vsync;
   logic [HW-1:0] o_hidx;
   logic [VW-1:0] o_vidx;
   logic [3:0]    o_vga_red, o_vga_green, o_vga_blue;

   int total = 0;
   int bad   = 0;

   vga_timing_gen #(
      .CLK_DIV   (D),
      .H_ACTIVE  (HA),
      .H_FP      (HFP),
      .H_SYNC    (HS),
      .H_BP      (HBP),
      .V_ACTIVE  (VA),
      .V_FP      (VFP),
      .V_SYNC    (VS),
      .V_BP      (VBP),
      .HSYNC_POL (HPOL),
      .VSYNC_POL (VPOL),
      .COLOR_W   (4)
   ) dut (
      .clk           (clk),
      .i_sclr        (i_sclr),
      .i_enb         (i_enb),
      .i_red         (i_red),
      .i_green       (i_green),
      .i_blue        (i_blue),
      .o_px_en       (o_px_en),
      .o_hidx        (o_hidx),
      .o_vidx        (o_vidx),
      .o_active      (o_active),
      .o_line_start  (o_line_start),
      .o_frame_start (o_frame_start),
      .o_vga_hsync   (o_vga_hsync),
      .o_vga_vsync   (o_vga_vsync),
      .o_vga_red     (o_vga_red),
      .o_vga_green   (o_vga_green),
      .o_vga_blue    (o_vga_blue)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: position is a pure function of the number of strobes since reset.
   longint     m_e = 0;    // enabled clocks since reset
   longint     m_n = 0;    // pixel strobes since reset
   bit         m_step = 1'b0;
   logic [3:0] m_r = 4'h0, m_g = 4'h0, m_b = 4'h0;
   bit         m_hs = !HPOL;
   bit         m_vs = !VPOL;

   function automatic int ph(input longint n);
      return (n == 0) ? HT - 1 : int'((n - 1) % HT);
   endfunction

   function automatic int pv(input longint n);
      return (n == 0) ? VT - 1 : int'(((n - 1) / HT) % VT);
   endfunction

   function automatic bit pact(input longint n);
      return (n > 0) && (ph(n) < HA) && (pv(n) < VA);
   endfunction

   function automatic logic [3:0] srcc(input int ch, input int h, input logic [3:0] ext);
`ifdef VGA_TIMING_PATTERN_EN
      int bar;
      bar = h / (HA / 8);
      if (bar > 7) bar = 7;
      return (((bar >> ch) & 1) != 0) ? 4'hF : 4'h0;
`else
      if (ch < 0) return 4'h0;
      if (h < 0) return 4'h0;
      return ext;
`endif
   endfunction

   initial begin : model
      bit px;
      int h, v;
      bit a;
      forever begin
         @(posedge clk or posedge i_sclr);
         if (i_sclr) begin
            m_e = 0; m_n = 0; m_step = 1'b0;
            m_r = 4'h0; m_g = 4'h0; m_b = 4'h0;
            m_hs = !HPOL; m_vs = !VPOL;
         end else begin
            px = i_enb && ((m_e % D) == D - 1);
            if (i_enb) m_e++;
            m_step = px;
            if (px) begin
               h = ph(m_n);
               v = pv(m_n);
               a = pact(m_n);
               m_r  = a ? srcc(0, h, i_red)   : 4'h0;
               m_g  = a ? srcc(1, h, i_green) : 4'h0;
               m_b  = a ? srcc(2, h, i_blue)  : 4'h0;
               m_hs = (h >= HA + HFP && h < HA + HFP + HS) ? HPOL : !HPOL;
               m_vs = (v >= VA + VFP && v < VA + VFP + VS) ? VPOL : !VPOL;
               m_n++;
            end
         end
      end
   end

   // Every-cycle comparison against the model, mid-cycle.
   initial begin : compare
      bit ep, el, ef;
      forever begin
         @(negedge clk);
         ep = !i_sclr && i_enb && ((m_e % D) == D - 1);
         el = !i_sclr && i_enb && m_step && (m_n > 0) && (ph(m_n) == 0);
         ef = el && (pv(m_n) == 0);
         chk("px_en", 32'(o_px_en), 32'(ep));
         chk("hidx", 32'(o_hidx), 32'(ph(m_n)));
         chk("vidx", 32'(o_vidx), 32'(pv(m_n)));
         chk("active", 32'(o_active), 32'(pact(m_n)));
         chk("line_start", 32'(o_line_start), 32'(el));
         chk("frame_start", 32'(o_frame_start), 32'(ef));
         chk("hsync", 32'(o_vga_hsync), 32'(m_hs));
         chk("vsync", 32'(o_vga_vsync), 32'(m_vs));
         chk("red", 32'(o_vga_red), 32'(m_r));
         chk("green", 32'(o_vga_green), 32'(m_g));
         chk("blue", 32'(o_vga_blue), 32'(m_b));
      end
   end

   // Advance to just after the next strobe edge.
   task automatic wait_px();
      for (int k = 0; k < 2 * D + 4; k++) begin
         @(negedge clk);
         if (o_px_en) begin
            @(posedge clk);
            #1;
            return;
         end
      end
      chk("px_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_h(input int target);
      for (int k = 0; k < 2 * HT * VT; k++) begin
         if (int'(o_hidx) == target) return;
         wait_px();
      end
      chk("hidx_timeout", 32'(o_hidx), 32'(target));
   endtask

   initial begin : stim
      int first, cnt, lows, vsc, seen, burst;
      bit found, prev_start;
      first = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_hidx", 32'(o_hidx), 32'd22);
      chk("rst_vidx", 32'(o_vidx), 32'd9);
      chk("rst_hsync", 32'(o_vga_hsync), 32'd1);
      chk("rst_vsync", 32'(o_vga_vsync), 32'd0);
      chk("rst_px_en", 32'(o_px_en), 32'd0);
      chk("rst_red", 32'(o_vga_red), 32'd0);

      @(posedge clk); #1;
      i_sclr = 1'b0;
      i_enb  = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (o_px_en) begin first = k; break; end
      end
      chk("first_px_clk", 32'(first), 32'd3);
      @(posedge clk); #1;
      chk("first_hidx", 32'(o_hidx), 32'd0);
      chk("first_vidx", 32'(o_vidx), 32'd0);
      chk("first_frame", 32'(o_frame_start), 32'd1);
      chk("first_line", 32'(o_line_start), 32'd1);
      chk("first_active", 32'(o_active), 32'd1);
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         cnt++;
         if (o_px_en) break;
      end
      chk("px_period", 32'(cnt), 32'd3);
      @(posedge clk); #1;

      // Last visible column then first blanked column.
      wait_h(HA - 1);
      i_red = 4'hA;
      wait_px();
`ifdef VGA_TIMING_PATTERN_EN
      chk("red_last_px", 32'(o_vga_red), 32'd15);
`else
      chk("red_last_px", 32'(o_vga_red), 32'd10);
`endif
      i_red = 4'hF;
      wait_px();
      chk("red_blank", 32'(o_vga_red), 32'd0);
      i_red = 4'h0;

      // Hsync starts one slot after hidx reaches the sync column.
      wait_h(HA + HFP);
      chk("hs_before", 32'(o_vga_hsync), 32'd1);
      wait_px();
      chk("hs_assert", 32'(o_vga_hsync), 32'd0);
      lows = 1;
      for (int k = 0; k < 2 * HT && o_vga_hsync == 1'b0; k++) begin
         wait_px();
         if (o_vga_hsync == 1'b0) lows++;
      end
      chk("hs_width", 32'(lows), 32'd3);

      wait_h(HT - 1);
      chk("pre_wrap_vidx", 32'(o_vidx), 32'd0);
      wait_px();
      chk("wrap_hidx", 32'(o_hidx), 32'd0);
      chk("wrap_vidx", 32'(o_vidx), 32'd1);
      chk("wrap_line", 32'(o_line_start), 32'd1);
      @(posedge clk); #1;
      chk("line_pulse_len", 32'(o_line_start), 32'd0);

      // One full frame between frame markers; vsync slot count and start.
      found = 1'b0;
      for (int k = 0; k < HT * VT + 2; k++) begin
         wait_px();
         if (o_frame_start) begin found = 1'b1; break; end
      end
      chk("frame_found", 32'(found), 32'd1);
      cnt = 0; vsc = 0; prev_start = 1'b0;
      for (int k = 0; k < 2 * HT * VT; k++) begin
         wait_px();
         cnt++;
         if (o_vga_vsync == VPOL) vsc++;
         if (prev_start) chk("vs_start", 32'(o_vga_vsync), 32'd1);
         prev_start = (int'(o_vidx) == VA + VFP) && (o_hidx == '0);
         if (prev_start) chk("vs_not_yet", 32'(o_vga_vsync), 32'd0);
         if (o_frame_start) break;
      end
      chk("frame_len", 32'(cnt), 32'd230);
      chk("vs_slots", 32'(vsc), 32'd46);

      // Freeze mid-line.
      wait_h(5);
      @(posedge clk); #1;
      i_enb = 1'b0;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (o_px_en || o_line_start || o_frame_start) seen++;
         @(posedge clk); #1;
      end
      chk("freeze_no_px", 32'(seen), 32'd0);
      i_enb = 1'b1;

      // Randomized enable, colour and one asynchronous mid-frame reset.
      burst = 0;
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1;
         i_red   = 4'($urandom);
         i_green = 4'($urandom);
         i_blue  = 4'($urandom);
         if (burst > 0) begin
            burst--;
            i_enb = 1'b0;
         end else if ($urandom_range(0, 39) == 0) begin
            burst = 9;
            i_enb = 1'b0;
         end else begin
            i_enb = ($urandom_range(0, 7) != 0);
         end
         if (c == 2000) begin #2; i_sclr = 1'b1; end
         if (c == 2002) i_sclr = 1'b0;
      end
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator and pixel output stage. It is the successor to the fixed 640x480 px_clk/hsync/vsync chain. It derives a pixel-enable strobe from the system clock, runs configurable horizontal and vertical counters, and decodes sync, active-video and frame/line markers. It also registers the colour outputs so they align with the syncs. It sits between the system clock and the VGA pins; image sources read o_hidx/o_vidx and drive i_red/i_green/i_blue.

Parameters:
CLK_DIV, 4, system clocks per pixel (>=1)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted level of hsync
VSYNC_POL, 0, asserted level of vsync
COLOR_W, 4, bits per colour channel

Ports:
clk  in  1  system clock
i_sclr  in  1  reset; asynchronous, active-high
i_enb  in  1  run enable; low freezes all state
i_red, i_green, i_blue  in  COLOR_W  pixel colour for current (o_hidx, o_vidx)
o_px_en  out  1  one-clk pixel strobe
o_hidx  out  clog2(H_TOTAL)  horizontal counter
o_vidx  out  clog2(V_TOTAL)  vertical counter
o_active  out  1  (o_hidx, o_vidx) inside visible area
o_line_start  out  1  one-clk pulse when o_hidx becomes 0
o_frame_start  out  1  one-clk pulse when (o_hidx, o_vidx) becomes (0,0)
o_vga_hsync, o_vga_vsync  out  1  sync pins, polarity per parameter
o_vga_red, o_vga_green, o_vga_blue  out  COLOR_W  colour pins

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Region order: active, front porch, sync, back porch.
- Reset (async, i_sclr=1):
  - divider=0
  - o_hidx=H_TOTAL-1, o_vidx=V_TOTAL-1
  - o_px_en, o_active, o_line_start, o_frame_start = 0
  - syncs = deasserted (~POL)
  - colours = 0
- Divider: counts 0..CLK_DIV-1 while i_enb. o_px_en=1 for the clk where divider==CLK_DIV-1. CLK_DIV=1 gives o_px_en constantly high while enabled.
- Counters and markers update on the clk edge at which o_px_en is sampled high:
  - o_hidx increments; at H_TOTAL-1 it wraps to 0 and o_vidx increments.
  - o_vidx wraps from V_TOTAL-1 to 0.
  - o_active, o_line_start and o_frame_start are registered on the same edge from the next counter values, so they are coherent with o_hidx/o_vidx.
  - o_line_start and o_frame_start last exactly one clk.
- First pixel strobe after reset wraps both counters and produces (0,0) with o_frame_start=1 and o_line_start=1.
- Output stage, one-pixel pipeline. On each px_en edge:
  - o_vga_* colour <= o_active ? source : 0.
  - o_vga_hsync <= HSYNC_POL if o_hidx in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~HSYNC_POL.
  - vsync is decoded the same way on o_vidx.
  - Result: pins lag o_hidx/o_vidx by exactly one pixel slot, and colour and syncs stay mutually aligned.
- i_enb=0: divider, counters, pins and markers hold; o_px_en, o_line_start, o_frame_start are forced 0. Resume continues from the held divider value.
- Reset asserted mid-frame: immediate return to reset values; no partial pulses after release.

Optional Feature:
VGA_TIMING_PATTERN_EN.
- Defined: i_red/i_green/i_blue are ignored. Source colour is an 8-bar test pattern:
  - bar = o_hidx / (H_ACTIVE/8), saturating at 7.
  - bar bit0 selects full-scale red, bit1 green, bit2 blue (all ones or 0).
  - Blanking, pipeline and sync timing are identical.
- Undefined: external colour pass-through as above. Ports are identical in both builds.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 default constants (H/V active, porches, syncs, CLK_DIV=4)
  - totals
  - a clog2 function
  - pattern bar colour constants
- One natural sub-module: px_en_div (divider plus i_enb gating, output o_px_en).
- Counters, decode and output stage stay in vga_timing_gen.

Test Plan:
- Reset release, defaults, i_enb=1 -> first o_px_en on 4th clk.
  - Same edge: (0,0) with o_frame_start=1, o_line_start=1, o_active=1.
  - o_px_en period is 4 clks.
- Run one full line -> o_hidx=655 (last front-porch pixel) on one px_en edge.
  - Next px_en edge: o_hidx=656 and o_vga_hsync still 1.
  - Following px_en edge: o_vga_hsync goes 0; it stays low for 96 pixel slots.
  - After o_hidx 799, o_hidx wraps to 0, o_vidx=1, o_line_start pulses once.
- Full frame -> 800*525 px_en per frame; o_vga_vsync low for 2 lines, starting one pixel after o_vidx becomes 490.
  - o_frame_start exactly once per 420000 px_en.
- i_red=4'hA at o_hidx=639 -> pins show 4'hA one slot later; at o_hidx=640 input 4'hF -> pins 0.
- i_enb low for 10 clks mid-line -> all outputs frozen, no strobes; sequence resumes without a skipped or duplicated index.
- CLK_DIV=1, H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, HSYNC_POL=1 -> line period 12 clks, hsync high 2 clks.
  - With VGA_TIMING_PATTERN_EN: colours step through bars 0..7, one pixel each.
